// File: rtl/key_cmd_gen.sv
// Turns held-key levels from the PS/2 decoder into discrete game commands with
// typematic repeat on direction keys, queued in a small FWFT buffer.
module key_cmd_gen #(
    parameter int DELAY_CYCLES  = 25_000_000,
    parameter int REPEAT_CYCLES = 10_000_000,
    parameter int DEPTH         = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     key_up,
    input  logic                     key_down,
    input  logic                     key_left,
    input  logic                     key_right,
    input  logic                     key_enter,
    input  logic                     cmd_ready,
    input  logic                     clr_ovf,
    output logic                     cmd_valid,
    output logic [2:0]               cmd_code,
    output logic                     cmd_repeat,
    output logic [$clog2(DEPTH):0]   fifo_count,
    output logic                     ovf
);

    localparam int AW   = $clog2(DEPTH);
    localparam int MAXC = (DELAY_CYCLES > REPEAT_CYCLES) ? DELAY_CYCLES : REPEAT_CYCLES;
    localparam int CW   = $clog2(MAXC);
    localparam logic [CW-1:0] DLY_LAST = CW'(DELAY_CYCLES - 1);
    localparam logic [CW-1:0] RPT_LAST = CW'(REPEAT_CYCLES - 1);
    localparam logic [AW:0]   FULL_CNT = (AW + 1)'(DEPTH);

    typedef enum logic [1:0] {IDLE, DELAY, REPEAT} state_t;

    state_t          state;
    logic [CW-1:0]   counter;
    logic [2:0]      active;
    logic [4:0]      k_q, k_qq, rise;
    logic [3:0]      dir_rise;
    logic            enter_rise, any_dir, active_held, period_last, rpt_fire;
    logic [2:0]      new_code;
    logic            push_en, push_rep;
    logic [2:0]      push_code;

    logic [2:0]      mem_code [DEPTH];
    logic            mem_rep  [DEPTH];
    logic [AW-1:0]   wr_ptr, rd_ptr;
    logic            pop, full, wr_en, ovf_set;

    // Bit index is command code minus one: up, down, left, right, enter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            k_q  <= '0;
            k_qq <= '0;
        end else begin
            k_q  <= {key_enter, key_right, key_left, key_down, key_up};
            k_qq <= k_q;
        end
    end

    // Enter outranks every direction; a direction rising alongside it is discarded.
    always_comb begin
        rise       = k_q & ~k_qq;
        enter_rise = rise[4];
        dir_rise   = rise[3:0] & {4{~enter_rise}};
        any_dir    = |dir_rise;
        new_code   = 3'd0;
        for (int i = 3; i >= 0; i--) begin
            if (dir_rise[i]) new_code = 3'(i + 1);
        end
        case (active)
            3'd1:    active_held = k_q[0];
            3'd2:    active_held = k_q[1];
            3'd3:    active_held = k_q[2];
            3'd4:    active_held = k_q[3];
            default: active_held = 1'b0;
        endcase
        period_last = ((state == DELAY)  && (counter == DLY_LAST)) ||
                      ((state == REPEAT) && (counter == RPT_LAST));
        rpt_fire  = (state != IDLE) && !any_dir && active_held && period_last;
        push_en   = enter_rise | any_dir | rpt_fire;
        push_code = enter_rise ? 3'd5 : (any_dir ? new_code : active);
        push_rep  = rpt_fire & ~enter_rise;
    end

    // A repeat preempted by Enter is lost, but the period still restarts.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            counter <= '0;
            active  <= '0;
        end else if (any_dir) begin
            state   <= DELAY;
            counter <= '0;
            active  <= new_code;
        end else if (state != IDLE) begin
            if (!active_held) begin
                state   <= IDLE;
                counter <= '0;
                active  <= '0;
            end else if (period_last) begin
                state   <= REPEAT;
                counter <= '0;
            end else begin
                counter <= counter + CW'(1);
            end
        end
    end

    assign pop     = cmd_valid & cmd_ready;
    assign full    = (fifo_count == FULL_CNT);
    assign wr_en   = push_en & (~full | pop);
    assign ovf_set = push_en & full & ~pop;

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_code[wr_ptr] <= push_code;
            mem_rep[wr_ptr]  <= push_rep;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
            ovf        <= 1'b0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + AW'(1);
            if (pop)   rd_ptr <= rd_ptr + AW'(1);
            case ({wr_en, pop})
                2'b10:   fifo_count <= fifo_count + (AW + 1)'(1);
                2'b01:   fifo_count <= fifo_count - (AW + 1)'(1);
                default: fifo_count <= fifo_count;
            endcase
            if (ovf_set)      ovf <= 1'b1;
            else if (clr_ovf) ovf <= 1'b0;
        end
    end

    assign cmd_valid  = (fifo_count != '0);
    assign cmd_code   = cmd_valid ? mem_code[rd_ptr] : 3'd0;
    assign cmd_repeat = cmd_valid ? mem_rep[rd_ptr]  : 1'b0;

endmodule

// File: tb/tb_key_cmd_gen.sv
// Scoreboard bench for key_cmd_gen: a cycle-level reference model schedules repeats
// from press timestamps and a negedge monitor checks the queue head and status.
module tb_key_cmd_gen;

    localparam int DLY   = 8;
    localparam int RPT   = 4;
    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [5:1] keys = '0;
    logic       cmd_ready = 1'b0;
    logic       clr_ovf = 1'b0;
    logic       cmd_valid;
    logic [2:0] cmd_code;
    logic       cmd_repeat;
    logic [2:0] fifo_count;
    logic       ovf;

    typedef struct packed {
        logic [2:0] code;
        logic       rep;
    } entry_t;

    entry_t     sb[$];
    int         nvec = 0;
    int         nerr = 0;

    logic [5:1] held_m = '0;
    logic [5:1] prev_m = '0;
    int         active_m = 0;
    int         t0 = 0;
    int         cyc = 0;
    int         mcount = 0;
    logic       ovf_m = 1'b0;

    always #5 clk = ~clk;

    key_cmd_gen #(
        .DELAY_CYCLES (DLY),
        .REPEAT_CYCLES(RPT),
        .DEPTH        (DEPTH)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .key_up    (keys[1]),
        .key_down  (keys[2]),
        .key_left  (keys[3]),
        .key_right (keys[4]),
        .key_enter (keys[5]),
        .cmd_ready (cmd_ready),
        .clr_ovf   (clr_ovf),
        .cmd_valid (cmd_valid),
        .cmd_code  (cmd_code),
        .cmd_repeat(cmd_repeat),
        .fifo_count(fifo_count),
        .ovf       (ovf)
    );

    task automatic checkOutput(input string name, input int act, input int exp);
        nvec++;
        if (act != exp) begin
            nerr++;
            $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic bit repeatDue(input int elapsed);
        return (elapsed >= DLY) && (((elapsed - DLY) % RPT) == 0);
    endfunction

    // Reference model: repeats fall on fixed offsets from the latest direction press.
    task automatic modelStep();
        logic [5:1] rose;
        entry_t     e;
        bit         push, pop, ovfset;
        int         dir;
        rose   = held_m & ~prev_m;
        push   = 1'b0;
        ovfset = 1'b0;
        dir    = 0;
        e      = '0;
        for (int c = 4; c >= 1; c--) begin
            if (rose[c]) dir = c;
        end
        if (rose[5]) begin
            push = 1'b1;
            e.code = 3'd5;
            e.rep = 1'b0;
            dir = 0;
        end
        if (dir != 0) begin
            active_m = dir;
            t0 = cyc;
            push = 1'b1;
            e.code = 3'(dir);
            e.rep = 1'b0;
        end else if (active_m != 0 && !held_m[active_m]) begin
            active_m = 0;
        end else if (active_m != 0 && repeatDue(cyc - t0) && !push) begin
            push = 1'b1;
            e.code = 3'(active_m);
            e.rep = 1'b1;
        end
        pop = (mcount > 0) && cmd_ready;
        if (push) begin
            if (mcount < DEPTH || pop) begin
                sb.push_back(e);
                mcount++;
            end else begin
                ovfset = 1'b1;
            end
        end
        if (pop) mcount--;
        if (ovfset) ovf_m = 1'b1;
        else if (clr_ovf) ovf_m = 1'b0;
        prev_m = held_m;
        held_m = keys;
        cyc++;
    endtask

    initial forever begin
        @(posedge clk or negedge rst_n);
        if (!rst_n) begin
            held_m = '0;
            prev_m = '0;
            active_m = 0;
            mcount = 0;
            ovf_m = 1'b0;
            sb.delete();
        end else begin
            modelStep();
        end
    end

    initial forever begin
        @(negedge clk);
        checkOutput("fifo_count", int'(fifo_count), mcount);
        checkOutput("cmd_valid", int'(cmd_valid), int'(mcount != 0));
        checkOutput("ovf", int'(ovf), int'(ovf_m));
        if (cmd_valid) begin
            if (sb.size() == 0) begin
                checkOutput("head_expected", 0, 1);
            end else begin
                checkOutput("cmd_code", int'(cmd_code), int'(sb[0].code));
                checkOutput("cmd_repeat", int'(cmd_repeat), int'(sb[0].rep));
                if (cmd_ready && rst_n) void'(sb.pop_front());
            end
        end else begin
            checkOutput("empty_code", int'(cmd_code), 0);
            checkOutput("empty_repeat", int'(cmd_repeat), 0);
        end
    end

    task automatic applyStimulus(input logic [5:1] k, input logic rdy, input logic clr, input int n);
        keys = k;
        cmd_ready = rdy;
        clr_ovf = clr;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic doReset(input int n);
        rst_n = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
        rst_n = 1'b1;
    endtask

    initial begin
        logic [5:1] k;
        int         w;
        #1;
        doReset(3);
        $display("[TB] single pulse on Up");
        applyStimulus(5'b00001, 1'b1, 1'b0, 1);
        applyStimulus(5'b00000, 1'b1, 1'b0, 6);
        $display("[TB] hold Left into repeat");
        applyStimulus(5'b00100, 1'b1, 1'b0, 20);
        applyStimulus(5'b00000, 1'b1, 1'b0, 4);
        $display("[TB] Up held, Right takes over");
        applyStimulus(5'b00001, 1'b1, 1'b0, 5);
        applyStimulus(5'b01001, 1'b1, 1'b0, 20);
        applyStimulus(5'b01000, 1'b1, 1'b0, 10);
        applyStimulus(5'b00000, 1'b1, 1'b0, 4);
        $display("[TB] Enter and Down together");
        applyStimulus(5'b10010, 1'b1, 1'b0, 30);
        applyStimulus(5'b00000, 1'b1, 1'b0, 4);
        $display("[TB] fill queue with consumer stalled");
        for (int i = 0; i < 5; i++) begin
            applyStimulus(5'b10000, 1'b0, 1'b0, 1);
            applyStimulus(5'b00000, 1'b0, 1'b0, 1);
        end
        applyStimulus(5'b00000, 1'b0, 1'b0, 2);
        applyStimulus(5'b10000, 1'b0, 1'b0, 1);
        applyStimulus(5'b00000, 1'b1, 1'b0, 1);
        applyStimulus(5'b00000, 1'b0, 1'b0, 2);
        applyStimulus(5'b00000, 1'b0, 1'b1, 1);
        applyStimulus(5'b00000, 1'b1, 1'b0, 8);
        $display("[TB] reset while Down repeats");
        applyStimulus(5'b00010, 1'b1, 1'b0, 16);
        doReset(2);
        applyStimulus(5'b00010, 1'b1, 1'b0, 18);
        applyStimulus(5'b00000, 1'b1, 1'b0, 4);
        $display("[TB] randomized phase");
        for (int s = 0; s < 60; s++) begin
            k = 5'($urandom_range(0, 31)) & 5'($urandom_range(0, 31));
            applyStimulus(k, 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 15) == 0),
                          $urandom_range(1, 14));
        end
        w = 0;
        while ((sb.size() != 0 || mcount != 0) && w < 50) begin
            applyStimulus(5'b00000, 1'b1, 1'b0, 1);
            w++;
        end
        checkOutput("drain_left", sb.size(), 0);
        applyStimulus(5'b00000, 1'b1, 1'b1, 2);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
